instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/ifu_next_pc.sv | 26 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg
// Shared definitions for the instruction fetch unit:
//   ifu_state_e       - fetch FSM state encoding (REQ, WAIT, HOLD)
//   PC_STEP_DEFAULT   - default sequential PC increment in bytes
//   RESET_PC_DEFAULT  - default PC value loaded on reset
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_e;

  localparam int unsigned PC_STEP_DEFAULT  = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
// Instruction-memory bus between the fetch unit and the instruction memory.
//   IMEM_READ      - read request (fetch unit -> memory)
//   IMEM_ADDRESS   - read address, always the current PC (fetch unit -> memory)
//   IMEM_READDATA  - read data (memory -> fetch unit)
//   IMEM_BUSYWAIT  - memory busy, read data not yet valid (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if;

  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_READ,
    output IMEM_ADDRESS,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_READ,
    input  IMEM_ADDRESS,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );

endinterface

// File: rtl/ifu_next_pc.sv
// ifu_next_pc
// Combinational next-PC computation for the fetch unit.
//   pc             in  32  current PC
//   branch_taken   in  1   select the branch target instead of the increment
//   branch_target  in  32  redirect address; its low two bits are cleared
//   next_pc        out 32  pc + PC_STEP (modulo 2^32) or word-aligned target
module ifu_next_pc
  import ifu_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc
);

  always_comb begin
    if (branch_taken) begin
      next_pc = branch_target & ~32'h0000_0003;
    end else begin
      next_pc = pc + 32'(PC_STEP);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Three-state fetch unit (REQ -> WAIT -> HOLD): requests the word at PC,
// waits out IMEM_BUSYWAIT, then presents it to the CPU until consumed.
// Ports:
//   CLK, RESET     in       clock, asynchronous active-high reset
//   PC             out 32   address of the instruction fetched or held
//   INSTRUCTION    out 32   fetched instruction word
//   INSTR_VALID    out 1    INSTRUCTION valid for the CPU (HOLD state)
//   STALL          in  1    CPU cannot consume INSTRUCTION this cycle
//   BRANCH_TAKEN   in  1    redirect to BRANCH_TARGET at the consuming edge
//   BRANCH_TARGET  in  32   redirect address
//   imem           master   instruction-memory bus (instr_fetch_unit_if)
//   FETCH_COUNT    out 32   consumed-instruction counter
//   MISS_CYCLES    out 32   memory-wait cycle counter
// Macro IFU_PERF_COUNTERS_EN: when defined, the two counters are built;
// otherwise they read as constant zero.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                      CLK,
  input  logic                      RESET,
  output logic [31:0]               PC,
  output logic [31:0]               INSTRUCTION,
  output logic                      INSTR_VALID,
  input  logic                      STALL,
  input  logic                      BRANCH_TAKEN,
  input  logic [31:0]               BRANCH_TARGET,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               FETCH_COUNT,
  output logic [31:0]               MISS_CYCLES
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic        consume;
  logic        capture;

  assign consume = (state_q == HOLD) && !STALL;
  assign capture = (state_q == WAIT) && !imem.IMEM_BUSYWAIT;

  ifu_next_pc #(
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .pc            (pc_q),
    .branch_taken  (BRANCH_TAKEN),
    .branch_target (BRANCH_TARGET),
    .next_pc       (next_pc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = WAIT;
      WAIT:    if (!imem.IMEM_BUSYWAIT) state_d = HOLD;
      HOLD:    if (!STALL) state_d = REQ;
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      if (consume) pc_q    <= next_pc;
      if (capture) instr_q <= imem.IMEM_READDATA;
    end
  end

  // The state register already sits in REQ while RESET is high, so the read
  // request is additionally gated by RESET to keep the bus idle during reset.
  assign imem.IMEM_READ    = !RESET && (state_q != HOLD);
  assign imem.IMEM_ADDRESS = pc_q;
  assign PC                = pc_q;
  assign INSTRUCTION       = instr_q;
  assign INSTR_VALID       = (state_q == HOLD);

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] miss_cycles_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_count_q <= '0;
      miss_cycles_q <= '0;
    end else begin
      if (consume) fetch_count_q <= fetch_count_q + 32'd1;
      if ((state_q == WAIT) && imem.IMEM_BUSYWAIT) miss_cycles_q <= miss_cycles_q + 32'd1;
    end
  end

  assign FETCH_COUNT = fetch_count_q;
  assign MISS_CYCLES = miss_cycles_q;
`else
  assign FETCH_COUNT = '0;
  assign MISS_CYCLES = '0;
`endif

endmodule
